fsm_pkt_gen: RTL and testbench
==============================

# fsm_pkt_gen

Packet generator for the word-framed bus checked by the packet-checking FSM. Each output packet is built as: top word = header (all ones), bottom word = rolling sequence number, middle words = payload taken from an upstream valid/ready source. The output is registered with a valid/ready handshake. It feeds the receive path (word-inverting register bank plus checker FSM) directly, or through a loop-back in test benches.

## Interface
- BUS_SIZE, 16, output bus width in bits; must be a multiple of WORD_SIZE and at least 3*WORD_SIZE.
- WORD_SIZE, 4, width of header, sequence and payload words.
- PL_SIZE, BUS_SIZE-2*WORD_SIZE, payload width (derived; do not override).
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  generator run request.
- seq_clr  in  1  synchronous clear of the sequence counter; honoured only in IDLE.
- pl_data  in  PL_SIZE  payload for the next packet.
- pl_valid  in  1  pl_data is valid.
- pl_ready  out  1  generator accepts pl_data this cycle.
- out_ready  in  1  downstream accepts bus_data_out this cycle.
- bus_data_out  out  BUS_SIZE  registered packet.
- bus_valid  out  1  bus_data_out holds a packet.
- seq_num  out  WORD_SIZE  sequence value for the next packet loaded.
- state  out  2  current FSM state.

## Operation
- Packet layout: [BUS_SIZE-1 -: WORD_SIZE] = {WORD_SIZE{1'b1}}; [WORD_SIZE +: PL_SIZE] = pl_data; [WORD_SIZE-1:0] = seq_num at load time.
- Slot free: free = !bus_valid || out_ready.
- Load: occurs when state==ACTIVE && enable && pl_valid && free. On load, bus_data_out is written, bus_valid is set, and seq_num increments by 1 modulo 2^WORD_SIZE (0xF wraps to 0x0).
- pl_ready = (state==ACTIVE) && enable && free. It is combinational, does not depend on pl_valid, and may depend on out_ready.
- Output drain without reload: bus_valid && out_ready && no load → bus_valid clears. bus_data_out keeps its last value.
- Stability: while bus_valid && !out_ready, bus_data_out and seq_num stay constant.
- FSM states are IDLE=0, ACTIVE=1, DRAIN=2.
  - IDLE: pl_ready=0. enable=1 → ACTIVE. seq_clr=1 → seq_num=0. seq_clr and enable together → clear first, then go to ACTIVE.
  - ACTIVE: enable=0 with bus_valid && !out_ready → DRAIN. enable=0 otherwise → IDLE. There is no load in the cycle enable is low.
  - DRAIN: pl_ready=0. The pending word is held until out_ready=1, then the state goes to IDLE with bus_valid=0.
- seq_num is not reset by IDLE. Only reset or seq_clr restarts it, so the stream stays continuous across pauses.
- seq_clr outside IDLE is ignored.

## Timing
- Reset values (asynchronous, as soon as reset=0): bus_data_out=0, bus_valid=0, seq_num=0, state=IDLE, pl_ready=0.
- Reset during a transfer discards the pending packet. The first packet after release carries seq 0.
- Latency: payload accepted at edge N appears on bus_data_out after edge N, i.e. one cycle.
- Throughput: one packet per cycle while pl_valid, out_ready and enable are all held high.
- Cycles after reset release: enable high at edge 1 → ACTIVE; first load at edge 2 at the earliest.

## Configuration
- PKT_GEN_ERR_INJ_EN defined: adds inputs inj_hdr and inj_seq (1 bit each), both sampled on a load.
  - inj_hdr=1: the header word is loaded with its LSB cleared (0xE for WORD_SIZE=4).
  - inj_seq=1: seq_num advances by 2 instead of 1, so the next packet skips one value. The loaded packet itself carries the current seq_num.
- Macro not defined: the ports do not exist and every packet is well-formed.

## Structure
- Shared package pkt_pkg holds:
  - FSM state encoding (IDLE/ACTIVE/DRAIN);
  - header constant (all ones of WORD_SIZE);
  - the corrupted-header constant.
- The checker FSM imports the same header constant.
- Sub-module seq_counter (parameter WORD_SIZE) contains the modulo counter with inc, inc2 and clr inputs, async active-low reset, and output value.

## Test plan
- Reset, then enable=1, pl_valid=1, out_ready=1, pl_data 0xA5, 0x3C → bus_data_out 0xFA50 then 0xF3C1; bus_valid is 1 from the cycle after the first load.
- 17 back-to-back loads with pl_data=0x00 → the 16th is 0xF00F, the 17th is 0xF000 (wrap).
- out_ready=0 for 3 cycles with bus_valid=1 → bus_data_out stable, pl_ready=0, seq_num unchanged; out_ready=1 → transfer completes and the next load occurs in the same cycle.
- enable dropped while bus_valid=1 and out_ready=0 → state=DRAIN, word held; out_ready=1 → state=IDLE, bus_valid=0. Re-enable → seq continues, with no reset to 0.
- reset driven low mid-stream at seq 0x7 → outputs 0 immediately, without waiting for a clock edge; after release the first packet is 0xF??0.
- With PKT_GEN_ERR_INJ_EN: inj_hdr on load of payload 0x12 at seq 3 → 0xE123. inj_seq on the next load → next packet carries seq 4, the following one carries seq 6.

Source files
------------

// File: rtl/pkt_pkg.sv
// Shared definitions for the packet generator and the packet-checking FSM:
// state encoding plus the well-formed and corrupted header words.
package pkt_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  // Wide constants; users slice the low WORD_SIZE bits.
  localparam int unsigned    HDR_MAX_W = 32;
  localparam logic [HDR_MAX_W-1:0] HDR_WORD = '1;
  localparam logic [HDR_MAX_W-1:0] HDR_BAD  = {{(HDR_MAX_W-1){1'b1}}, 1'b0};

endpackage

// File: rtl/seq_counter.sv
// Modulo 2^WORD_SIZE sequence counter with clear, +1 and +2 steps.
module seq_counter #(
  parameter int WORD_SIZE = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 inc,
  input  logic                 inc2,
  output logic [WORD_SIZE-1:0] value
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc2) begin
      value <= value + WORD_SIZE'(2);
    end else if (inc) begin
      value <= value + WORD_SIZE'(1);
    end
  end

endmodule

// File: rtl/fsm_pkt_gen.sv
// Packet generator: {header, payload, sequence} words on a registered valid/ready bus.
// Optional error injection (inj_hdr / inj_seq ports) when PKT_GEN_ERR_INJ_EN is defined.
module fsm_pkt_gen
  import pkt_pkg::*;
#(
  parameter int BUS_SIZE  = 16,
  parameter int WORD_SIZE = 4,
  parameter int PL_SIZE   = BUS_SIZE - 2*WORD_SIZE
) (
`ifdef PKT_GEN_ERR_INJ_EN
  input  logic                 inj_hdr,
  input  logic                 inj_seq,
`endif
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 seq_clr,
  input  logic [PL_SIZE-1:0]   pl_data,
  input  logic                 pl_valid,
  output logic                 pl_ready,
  input  logic                 out_ready,
  output logic [BUS_SIZE-1:0]  bus_data_out,
  output logic                 bus_valid,
  output logic [WORD_SIZE-1:0] seq_num,
  output logic [1:0]           state
);

  state_t               st;
  logic                 free;
  logic                 load;
  logic                 hdr_err;
  logic                 seq_skip;
  logic [WORD_SIZE-1:0] hdr;

`ifdef PKT_GEN_ERR_INJ_EN
  assign hdr_err  = inj_hdr;
  assign seq_skip = inj_seq;
`else
  assign hdr_err  = 1'b0;
  assign seq_skip = 1'b0;
`endif

  assign free     = !bus_valid || out_ready;
  assign pl_ready = (st == ACTIVE) && enable && free;
  assign load     = pl_ready && pl_valid;
  assign hdr      = hdr_err ? HDR_BAD[WORD_SIZE-1:0] : HDR_WORD[WORD_SIZE-1:0];
  assign state    = st;

  seq_counter #(
    .WORD_SIZE (WORD_SIZE)
  ) u_seq (
    .clk   (clk),
    .reset (reset),
    .clr   ((st == IDLE) && seq_clr),
    .inc   (load && !seq_skip),
    .inc2  (load && seq_skip),
    .value (seq_num)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st           <= IDLE;
      bus_valid    <= 1'b0;
      bus_data_out <= '0;
    end else begin
      // Output slot: a load overwrites, otherwise an accepted word just empties it.
      if (load) begin
        bus_data_out <= {hdr, pl_data, seq_num};
        bus_valid    <= 1'b1;
      end else if (bus_valid && out_ready) begin
        bus_valid    <= 1'b0;
      end

      case (st)
        IDLE: begin
          if (enable) st <= ACTIVE;
        end
        ACTIVE: begin
          if (!enable) st <= (bus_valid && !out_ready) ? DRAIN : IDLE;
        end
        DRAIN: begin
          if (out_ready) st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_pkt_gen.sv
// Self-checking bench for fsm_pkt_gen: directed scenarios plus random traffic against a packet-level model.
module tb_fsm_pkt_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        seq_clr = 1'b0;
  logic        pl_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  pl_data = 8'h00;
  logic        pl_ready;
  logic [15:0] bus_data_out;
  logic        bus_valid;
  logic [3:0]  seq_num;
  logic [1:0]  state;
`ifdef PKT_GEN_ERR_INJ_EN
  logic        inj_hdr = 1'b0;
  logic        inj_seq = 1'b0;
`endif

  fsm_pkt_gen #(
    .BUS_SIZE  (16),
    .WORD_SIZE (4)
  ) dut (
`ifdef PKT_GEN_ERR_INJ_EN
    .inj_hdr      (inj_hdr),
    .inj_seq      (inj_seq),
`endif
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .seq_clr      (seq_clr),
    .pl_data      (pl_data),
    .pl_valid     (pl_valid),
    .pl_ready     (pl_ready),
    .out_ready    (out_ready),
    .bus_data_out (bus_data_out),
    .bus_valid    (bus_valid),
    .seq_num      (seq_num),
    .state        (state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Packet-level reference: mode 0 idle, 1 running, 2 draining.
  int          m_mode;
  int          m_seq;
  bit          m_valid;
  logic [15:0] m_data;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_seq   = 0;
    m_valid = 1'b0;
    m_data  = 16'h0000;
  endtask

  // Inputs are already driven; check pl_ready, clock once, check registered outputs.
  task automatic step();
    bit   exp_ready;
    bit   ld;
    int   nxt;
    int   adv;
    logic [3:0] hdr;
    #2;
    exp_ready = (m_mode == 1) && enable && (!m_valid || out_ready);
    check("pl_ready", {31'd0, pl_ready}, {31'd0, exp_ready});
    ld  = exp_ready && pl_valid;
    hdr = 4'hF;
    adv = 1;
`ifdef PKT_GEN_ERR_INJ_EN
    if (inj_hdr) hdr = 4'hE;
    if (inj_seq) adv = 2;
`endif
    @(posedge clk);
    nxt = m_mode;
    case (m_mode)
      0: begin
        if (seq_clr) m_seq = 0;
        if (enable) nxt = 1;
      end
      1: if (!enable) nxt = (m_valid && !out_ready) ? 2 : 0;
      2: if (out_ready) nxt = 0;
      default: nxt = 0;
    endcase
    if (ld) begin
      m_data  = (16'(hdr) << 12) | (16'(pl_data) << 4) | 16'(m_seq);
      m_valid = 1'b1;
      m_seq   = (m_seq + adv) % 16;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    m_mode = nxt;
    #1;
    check("bus_valid", {31'd0, bus_valid}, {31'd0, m_valid});
    check("bus_data_out", {16'd0, bus_data_out}, {16'd0, m_data});
    check("seq_num", {28'd0, seq_num}, m_seq);
    check("state", {30'd0, state}, m_mode);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    enable = 1'b0; pl_valid = 1'b0; seq_clr = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  logic [15:0] held;
  logic [3:0]  held_seq;
  int          guard;

  initial begin
    model_reset();
    #12;
    check("rst_data", {16'd0, bus_data_out}, 32'h0);
    check("rst_valid", {31'd0, bus_valid}, 32'h0);
    check("rst_seq", {28'd0, seq_num}, 32'h0);
    check("rst_state", {30'd0, state}, 32'h0);
    check("rst_ready", {31'd0, pl_ready}, 32'h0);

    // First two packets.
    do_reset();
    enable = 1'b1; pl_valid = 1'b1; out_ready = 1'b1; pl_data = 8'hA5;
    step();
    check("no_valid_before_load", {31'd0, bus_valid}, 32'h0);
    step();
    check("pkt0", {16'd0, bus_data_out}, 32'hFA50);
    check("pkt0_valid", {31'd0, bus_valid}, 32'h1);
    pl_data = 8'h3C;
    step();
    check("pkt1", {16'd0, bus_data_out}, 32'hF3C1);

    // Sequence wrap over 17 loads.
    do_reset();
    enable = 1'b1; pl_valid = 1'b1; out_ready = 1'b1; pl_data = 8'h00;
    step();
    for (int i = 0; i < 17; i++) begin
      step();
      if (i == 15) check("wrap_16th", {16'd0, bus_data_out}, 32'hF00F);
      if (i == 16) check("wrap_17th", {16'd0, bus_data_out}, 32'hF000);
    end

    // Backpressure: three stalled cycles, then release with a same-cycle reload.
    held = bus_data_out;
    held_seq = seq_num;
    out_ready = 1'b0; pl_data = 8'h77;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_data", {16'd0, bus_data_out}, {16'd0, held});
      check("stall_seq", {28'd0, seq_num}, {28'd0, held_seq});
    end
    out_ready = 1'b1; pl_data = 8'h55;
    step();
    check("stall_reload", {16'd0, bus_data_out}, {16'd0, 4'hF, 8'h55, held_seq});

    // Drop enable while stalled: drain, then resume without sequence restart.
    out_ready = 1'b0;
    step();
    held = bus_data_out;
    enable = 1'b0;
    step();
    check("drain_state", {30'd0, state}, 32'h2);
    step();
    check("drain_hold", {16'd0, bus_data_out}, {16'd0, held});
    out_ready = 1'b1;
    step();
    check("drain_idle", {30'd0, state}, 32'h0);
    check("drain_valid", {31'd0, bus_valid}, 32'h0);
    held_seq = seq_num;
    enable = 1'b1; pl_data = 8'h9E;
    step();
    step();
    check("resume_seq", {28'd0, bus_data_out[3:0]}, {28'd0, held_seq});

    // Asynchronous reset mid-stream at seq 7.
    do_reset();
    enable = 1'b1; pl_valid = 1'b1; out_ready = 1'b1; pl_data = 8'h3A;
    step();
    guard = 0;
    while (seq_num != 4'h7 && guard < 20) begin
      step();
      guard++;
    end
    check("reach_seq7", {28'd0, seq_num}, 32'h7);
    #2;
    reset = 1'b0;
    #1;
    check("async_data", {16'd0, bus_data_out}, 32'h0);
    check("async_valid", {31'd0, bus_valid}, 32'h0);
    check("async_seq", {28'd0, seq_num}, 32'h0);
    check("async_state", {30'd0, state}, 32'h0);
    check("async_ready", {31'd0, pl_ready}, 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    step();
    step();
    check("post_rst_seq", {28'd0, bus_data_out[3:0]}, 32'h0);
    check("post_rst_hdr", {28'd0, bus_data_out[15:12]}, 32'hF);

`ifdef PKT_GEN_ERR_INJ_EN
    // Header corruption at seq 3, then a sequence skip.
    do_reset();
    enable = 1'b1; pl_valid = 1'b1; out_ready = 1'b1; pl_data = 8'h00;
    step();
    for (int i = 0; i < 3; i++) step();
    inj_hdr = 1'b1; pl_data = 8'h12;
    step();
    check("inj_hdr_pkt", {16'd0, bus_data_out}, 32'hE123);
    inj_hdr = 1'b0; inj_seq = 1'b1; pl_data = 8'h34;
    step();
    check("inj_seq_pkt", {28'd0, bus_data_out[3:0]}, 32'h4);
    inj_seq = 1'b0;
    step();
    check("inj_seq_next", {28'd0, bus_data_out[3:0]}, 32'h6);
`endif

    // Random traffic.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      enable    = ($urandom_range(0, 9) != 0);
      pl_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      seq_clr   = ($urandom_range(0, 7) == 0);
      pl_data   = 8'($urandom);
`ifdef PKT_GEN_ERR_INJ_EN
      inj_hdr   = ($urandom_range(0, 7) == 0);
      inj_seq   = ($urandom_range(0, 7) == 0);
`endif
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
